// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath width defaults and fetch FSM state encoding,
// common to fetch_controller and ProgramCounter.
package cpu_defs;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    typedef enum logic [1:0] {
        FS_IDLE = IDLE,
        FS_REQ  = REQ,
        FS_HOLD = HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout.sv
// Counts REQ cycles without an acknowledge; expired fires on the cycle that
// would bring the count to TIMEOUT.
module fetch_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (count && cnt_q != 4'hF)
            cnt_d = cnt_q + 4'd1;
    end

    // count and clear are never active together, so no clear term is needed here
    assign expired = count && (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: requests the word at pc, holds it for the
// decoder and pulses enable_increment once per acknowledged fetch.
//   state | meaning
//   IDLE  | no fetch outstanding, waiting for halt/flush/error to clear
//   REQ   | imem_req asserted, waiting for imem_ack or timeout
//   HOLD  | instr_valid asserted, waiting for instr_ready
module fetch_controller
    import cpu_defs::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              enable_increment,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              flush,
    input  logic              halt,
    output logic              fetch_error
);

    fetch_state_e      state_q, state_d;
    logic              start_q;
    logic              imem_req_q, imem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic              en_inc_q, en_inc_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [15:0]       fetch_count_q, fetch_count_d;
    logic              tmo_clear, tmo_count, tmo_expired;

    fetch_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .count   (tmo_count),
        .expired (tmo_expired)
    );

    assign tmo_count = (state_q == FS_REQ) && !flush && !imem_ack;
    assign tmo_clear = (state_d == FS_REQ) && (state_q != FS_REQ);

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        err_d         = err_q;
        fetch_count_d = fetch_count_q;
        en_inc_d      = 1'b0;
        case (state_q)
            FS_IDLE: begin
                // start_q delays the first request by one edge after reset release
                if (!flush && !halt && !err_q && start_q)
                    state_d = FS_REQ;
            end
            FS_REQ: begin
                if (flush) begin
                    state_d = FS_IDLE;
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc;
                    en_inc_d   = 1'b1;
                    state_d    = FS_HOLD;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = FS_IDLE;
                end
            end
            FS_HOLD: begin
                if (flush) begin
                    state_d = FS_IDLE;
                end else if (instr_ready) begin
                    fetch_count_d = fetch_count_q + 16'd1;
                    state_d       = halt ? FS_IDLE : FS_REQ;
                end
            end
            default: state_d = FS_IDLE;
        endcase
        imem_req_d    = (state_d == FS_REQ);
        instr_valid_d = (state_d == FS_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FS_IDLE;
            start_q       <= 1'b0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            en_inc_q      <= 1'b0;
            err_q         <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= 1'b1;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            en_inc_q      <= en_inc_d;
            err_q         <= err_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_req         = imem_req_q;
    assign imem_addr        = imem_req_q ? pc : '0;
    assign instr_valid      = instr_valid_q;
    assign enable_increment = en_inc_q;
    assign fetch_error      = err_q;
    assign instr            = instr_q;
    assign instr_pc         = instr_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios then random traffic, checked
// against a transaction-level model of the fetch protocol.
module tb_fetch_controller;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc;
    logic        enable_increment;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic        halt;
    logic        fetch_error;

    fetch_controller #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .enable_increment (enable_increment),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .flush            (flush),
        .halt             (halt),
        .fetch_error      (fetch_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: phase 0 = waiting, 1 = request outstanding, 2 = word held
    int          m_phase;
    bit          m_armed;
    bit          m_inc;
    bit          m_err;
    int          m_wait;
    logic [15:0] m_instr;
    logic [7:0]  m_ipc;
    logic [7:0]  m_pc;
    int          m_cnt;
    int          ack_pct;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit h, input bit f, input bit a, input logic [15:0] d, input bit r);
        m_inc = 1'b0;
        case (m_phase)
            0: if (m_armed && !h && !f && !m_err) begin
                m_phase = 1;
                m_wait  = 0;
            end
            1: if (f) begin
                m_phase = 0;
            end else if (a) begin
                m_instr = d;
                m_ipc   = m_pc;
                m_inc   = 1'b1;
                m_phase = 2;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_err   = 1'b1;
                    m_phase = 0;
                end
            end
            default: if (f) begin
                m_phase = 0;
            end else if (r) begin
                m_cnt   = (m_cnt + 1) % 65536;
                m_phase = h ? 0 : 1;
                m_wait  = 0;
            end
        endcase
        m_armed = 1'b1;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic do_cycle(input bit h, input bit f, input bit a, input logic [15:0] d, input bit r);
        halt        = h;
        flush       = f;
        imem_ack    = a;
        imem_rdata  = d;
        instr_ready = r;
        model_step(h, f, a, d, r);
        @(posedge clk);
        #1;
        check_eq("imem_req", 32'(imem_req), 32'(m_phase == 1));
        check_eq("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
        check_eq("enable_increment", 32'(enable_increment), 32'(m_inc));
        check_eq("fetch_error", 32'(fetch_error), 32'(m_err));
        check_eq("fetch_count", 32'(dut.fetch_count_q), 32'(m_cnt));
        if (m_phase == 2) begin
            check_eq("instr", 32'(instr), 32'(m_instr));
            check_eq("instr_pc", 32'(instr_pc), 32'(m_ipc));
        end
        // program counter stand-in advances on the DUT pulse, the model on its own
        if (enable_increment === 1'b1) pc = pc + 8'd1;
        if (m_inc) m_pc = m_pc + 8'd1;
        #1;
        check_eq("imem_addr", 32'(imem_addr), (m_phase == 1) ? 32'(m_pc) : 32'd0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        halt        = 1'b0;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        reset       = 1'b1;
        pc          = '0;
        #1;
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_inc", 32'(enable_increment), 32'd0);
        check_eq("rst_err", 32'(fetch_error), 32'd0);
        check_eq("rst_instr", 32'(instr), 32'd0);
        check_eq("rst_instr_pc", 32'(instr_pc), 32'd0);
        check_eq("rst_count", 32'(dut.fetch_count_q), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'd0);
        m_phase = 0;
        m_armed = 1'b0;
        m_inc   = 1'b0;
        m_err   = 1'b0;
        m_wait  = 0;
        m_instr = '0;
        m_ipc   = '0;
        m_pc    = '0;
        m_cnt   = 0;
        ack_pct = ($urandom_range(0, 3) == 0) ? 3 : 50;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        pc          = '0;
        halt        = 1'b0;
        flush       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;

        // first fetch, ack on the second REQ cycle
        do_reset();
        do_cycle(0, 0, 0, 16'h0, 0);
        check_eq("no_early_req", 32'(imem_req), 32'd0);
        do_cycle(0, 0, 0, 16'h0, 0);
        check_eq("first_req", 32'(imem_req), 32'd1);
        do_cycle(0, 0, 0, 16'h0, 0);
        do_cycle(0, 0, 1, 16'hA5C3, 0);
        check_eq("d_instr", 32'(instr), 32'hA5C3);
        check_eq("d_instr_pc", 32'(instr_pc), 32'h00);
        check_eq("d_inc", 32'(enable_increment), 32'd1);

        // decoder stall for five cycles
        repeat (5) do_cycle(0, 0, 0, 16'h0, 0);
        check_eq("stall_instr", 32'(instr), 32'hA5C3);
        check_eq("stall_req", 32'(imem_req), 32'd0);

        // two more fetches with ready high, halting after the third handshake
        do_cycle(0, 0, 0, 16'h0, 1);
        check_eq("d_addr1", 32'(imem_addr), 32'h01);
        do_cycle(0, 0, 1, 16'h1111, 1);
        do_cycle(0, 0, 0, 16'h0, 1);
        check_eq("d_addr2", 32'(imem_addr), 32'h02);
        do_cycle(0, 0, 1, 16'h2222, 1);
        do_cycle(1, 0, 0, 16'h0, 1);
        check_eq("d_count3", 32'(dut.fetch_count_q), 32'd3);

        // flush coinciding with ack
        do_cycle(0, 0, 0, 16'h0, 0);
        do_cycle(0, 1, 1, 16'h1234, 0);
        check_eq("flush_valid", 32'(instr_valid), 32'd0);
        check_eq("flush_inc", 32'(enable_increment), 32'd0);
        check_eq("flush_req", 32'(imem_req), 32'd0);

        // memory never acknowledges
        do_cycle(0, 0, 0, 16'h0, 0);
        repeat (TIMEOUT) do_cycle(0, 0, 0, 16'h0, 0);
        check_eq("tmo_err", 32'(fetch_error), 32'd1);
        repeat (5) do_cycle(0, 0, 0, 16'h0, 0);
        check_eq("tmo_idle", 32'(imem_req), 32'd0);

        // reset while holding an instruction, then fetch resumes from 0
        do_reset();
        do_cycle(0, 0, 0, 16'h0, 0);
        do_cycle(0, 0, 0, 16'h0, 0);
        do_cycle(0, 0, 1, 16'h5A5A, 0);
        check_eq("pre_rst_valid", 32'(instr_valid), 32'd1);
        do_reset();
        do_cycle(0, 0, 0, 16'h0, 0);
        do_cycle(0, 0, 0, 16'h0, 0);
        check_eq("resume_addr", 32'(imem_addr), 32'h00);
        check_eq("resume_req", 32'(imem_req), 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ((m_err && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                bit          h, f, a, r;
                logic [15:0] d;
                h = ($urandom_range(0, 99) < 15);
                f = ($urandom_range(0, 99) < 4);
                a = (m_phase == 1) && ($urandom_range(0, 99) < ack_pct);
                r = ($urandom_range(0, 99) < 50);
                d = 16'($urandom);
                do_cycle(h, f, a, d, r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter ADDR_W, 8, width of the program-counter and instruction-memory address.
REQ-002 Parameter DATA_W, 16, width of the instruction word.
REQ-003 Parameter TIMEOUT, 15, maximum number of REQ cycles allowed without imem_ack.
REQ-004 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port pc, input, ADDR_W, current value of the ProgramCounter output.
REQ-007 Port enable_increment, output, 1, one-cycle pulse that advances the ProgramCounter.
REQ-008 Port imem_req, output, 1, instruction-memory read request.
REQ-009 Port imem_addr, output, ADDR_W, read address, combinationally equal to pc while imem_req=1, otherwise 0.
REQ-010 Port imem_ack, input, 1, read complete; imem_rdata is valid in the same cycle.
REQ-011 Port imem_rdata, input, DATA_W, instruction word from memory.
REQ-012 Port instr, output, DATA_W, fetched instruction held for the decoder.
REQ-013 Port instr_pc, output, ADDR_W, address the held instruction was fetched from.
REQ-014 Port instr_valid, output, 1, instr and instr_pc are valid.
REQ-015 Port instr_ready, input, 1, decoder accepts instr on a cycle where instr_valid=1.
REQ-016 Port flush, input, 1, PC is being redirected: discard any in-flight or held fetch.
REQ-017 Port halt, input, 1, suppresses the start of new fetches.
REQ-018 Port fetch_error, output, 1, sticky flag set on memory timeout.

Function
REQ-019 FSM states: IDLE, REQ, HOLD.
REQ-020 IDLE: all handshake outputs are 0; the FSM moves to REQ on the next edge when halt=0, flush=0 and fetch_error=0.
REQ-021 REQ: imem_req=1; on imem_ack=1 the block captures imem_rdata into instr and pc into instr_pc, then moves to HOLD.
REQ-022 enable_increment is registered and is high for exactly the first HOLD cycle after each acknowledged fetch; it is never high in IDLE or REQ.
REQ-023 HOLD: instr_valid=1; when instr_ready=1, the FSM goes to REQ if halt=0, otherwise to IDLE.
REQ-024 HOLD lasts at least one cycle, so the PC has already advanced when the next REQ drives imem_addr.
REQ-025 Latency: ack at edge N gives instr_valid=1 in cycle N+1; ready in cycle N+1 gives imem_req=1 in cycle N+2.
REQ-026 instr and instr_pc remain stable while instr_valid=1 and instr_ready=0.
REQ-027 A 4-bit timeout counter clears on entry to REQ and increments each REQ cycle without imem_ack.
REQ-028 When the timeout counter reaches TIMEOUT, fetch_error is set and the FSM returns to IDLE.
REQ-029 fetch_error clears only on reset.
REQ-030 flush=1 in any state forces IDLE on the next edge and drops instr_valid.
REQ-031 flush has priority over imem_ack, instr_ready and timeout.
REQ-032 When flush and imem_ack occur in the same cycle, the data is discarded and enable_increment is not pulsed.
REQ-033 halt=1 in REQ does not abort the outstanding request.
REQ-034 halt=1 in HOLD does not withdraw instr_valid.
REQ-035 A 16-bit fetch_count, internal and visible to the bench, increments on each accepted instr_valid&&instr_ready handshake and wraps from 0xFFFF to 0.

Reset
REQ-036 Reset asserted at any time sets state=IDLE, instr=0, instr_pc=0, instr_valid=0, imem_req=0, enable_increment=0, fetch_error=0, fetch_count=0 and the timeout counter to 0.
REQ-037 Reset asserted during REQ or HOLD abandons the transaction without generating an enable_increment pulse.
REQ-038 The first imem_req after reset release appears no earlier than the second rising edge after release.

Structure
REQ-039 State encoding localparams (IDLE=0, REQ=1, HOLD=2) and the ADDR_W and DATA_W defaults live in the shared cpu_defs package and are shared with ProgramCounter.
REQ-040 The timeout counter is the natural sub-module, named fetch_timeout.
REQ-041 fetch_timeout has inputs clk, reset, clear and count, and outputs expired.

Verification
REQ-042 Reset, then halt=0, pc=0x00, ack on the 2nd REQ cycle with rdata=0xA5C3 -> instr=0xA5C3, instr_pc=0x00, one enable_increment pulse.
REQ-043 With ProgramCounter instantiated and ready held high, three fetches -> imem_addr sequence 0x00, 0x01, 0x02 and fetch_count=3.
REQ-044 instr_ready held 0 for 5 cycles in HOLD -> instr stable, no imem_req, no extra enable_increment.
REQ-045 flush in the same cycle as imem_ack -> instr_valid=0, enable_increment=0 and IDLE on the next cycle.
REQ-046 imem_ack never asserted -> fetch_error=1 after 15 REQ cycles and the block stays IDLE until reset.
REQ-047 Reset during HOLD -> all outputs are 0 immediately, and normal fetch resumes from pc=0x00.
